wifi_rx_stop_convolution_half: RTL and testbench
================================================

# wifi_rx_stop_convolution_half

Serial-to-parallel regrouper on the WIFI receive path. It collects the serial code-bit stream from the demapper/deinterleaver into rate-1/2 code pairs and presents one pair per output strobe to the Viterbi decoder. It mirrors the transmit-side half-rate P/S: the TX sends bit [1] of each pair first, then bit [0], so the first received bit of a pair lands in the upper field. It also tracks frame alignment, flags odd-length frames and counts pairs per frame.

## Interface
- SOFT_W, 1: width of one code bit (1 = hard decision; >1 = soft metric, passed through unmodified).
- CNT_W, 12: width of the per-frame pair counter.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  data_in carries one code bit this cycle.
- start_in  in  1  qualified by valid_in: this bit is the first code bit of a new frame.
- data_in  in  SOFT_W  serial code bit.
- valid_out  out  1  one-cycle strobe: data_out holds a new pair.
- data_out  out  2*SOFT_W  {first bit, second bit}; first bit in [2*SOFT_W-1:SOFT_W].
- pair_cnt  out  CNT_W  pairs emitted since the last start_in, including the one on data_out.
- odd_err  out  1  one-cycle pulse: a frame ended or was restarted with an unpaired bit pending.

## Operation
- State: phase (FIRST/SECOND), hold register (SOFT_W), pair counter.
- Reset values: valid_out=0, data_out=0, pair_cnt=0, odd_err=0, phase=FIRST, hold=0.
- valid_in=0: phase, hold and counter are unchanged, and valid_out=0. Gaps of any length between the two bits of a pair are legal.
- valid_in=1, start_in=0, phase=FIRST: hold<=data_in, phase<=SECOND.
- valid_in=1, start_in=0, phase=SECOND: data_out<={hold,data_in}, valid_out<=1, pair_cnt<=pair_cnt+1 (wraps modulo 2^CNT_W), phase<=FIRST.
- valid_in=1, start_in=1: the bit is always taken as a FIRST bit.
  - hold<=data_in, phase<=SECOND.
  - pair_cnt<=0.
  - If phase was SECOND, the pending hold is discarded and odd_err<=1.
- start_in with valid_in=0 is ignored.
- data_out is not cleared between pairs; it holds the last pair until the next one.
- Counter reset and increment never coincide, because a start bit is never a SECOND bit.

## Timing
- Latency: valid_out and data_out update on the clock edge following the cycle in which the second bit is presented with valid_in=1. That is one register stage.
- Maximum throughput is one pair every 2 clocks with valid_in continuously high. valid_out is then high every other cycle, never two cycles in a row.
- odd_err is asserted in the cycle after the offending start bit, for exactly one cycle.
- pair_cnt updates on the same edge as valid_out and reads 0 from the edge after a start bit until the first pair of that frame.
- Asserting reset mid-pair clears everything immediately (asynchronously). The next valid bit after release is a FIRST bit.

## Structure
- Shared package wifi_rx_pkg holds:
  - the phase encoding constants PH_FIRST=1'b0 and PH_SECOND=1'b1;
  - the default SOFT_W;
  - the default CNT_W.
- The block is a single module with no sub-module; the datapath is too small to split.

## Test plan
- Reset, then continuous valid_in with SOFT_W=1, start on the first bit, bits 1,0,1,1,0,1 -> valid_out pulses on three edges with data_out=2'b10, 2'b11, 2'b01, pair_cnt=1,2,3, odd_err=0.
- Same 6 bits with valid_in toggling 1,0,0,1 between bits -> identical data_out and pair_cnt sequence; no valid_out during gaps.
- 3 bits (a,b,c), then start_in with bit d, then bit e -> pair {a,b}; odd_err pulses once; c discarded; next pair {d,e} with pair_cnt=1.
- SOFT_W=4: bits 4'h9 then 4'h3 -> data_out=8'h93.
- CNT_W=2: 5 pairs after a start -> pair_cnt 1,2,3,0,1.
- Reset asserted after a FIRST bit, released, then bits 0,1 -> single pair 2'b01; no stale hold data; all outputs 0 during reset.

Source files
------------

// File: rtl/wifi_rx_pkg.sv
// wifi_rx_pkg: shared phase encoding and default widths for the WIFI RX path
package wifi_rx_pkg;
  localparam logic PH_FIRST   = 1'b0;
  localparam logic PH_SECOND  = 1'b1;
  localparam int   DEF_SOFT_W = 1;
  localparam int   DEF_CNT_W  = 12;
endpackage

// File: rtl/wifi_rx_stop_convolution_half.sv
// wifi_rx_stop_convolution_half: regroups serial code bits into rate-1/2 pairs with frame alignment tracking
module wifi_rx_stop_convolution_half
  import wifi_rx_pkg::*;
#(
  parameter int SOFT_W = DEF_SOFT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic                start_in,
  input  logic [SOFT_W-1:0]   data_in,
  output logic                valid_out,
  output logic [2*SOFT_W-1:0] data_out,
  output logic [CNT_W-1:0]    pair_cnt,
  output logic                odd_err
);
  logic              phase;
  logic [SOFT_W-1:0] hold;
  // a start bit is always a first bit; a second bit completes the pair held from the previous valid bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase     <= PH_FIRST;
      hold      <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      pair_cnt  <= '0;
      odd_err   <= 1'b0;
    end else begin
      valid_out <= valid_in && !start_in && phase == PH_SECOND;
      odd_err   <= valid_in && start_in && phase == PH_SECOND;
      if (valid_in) begin
        if (start_in || phase == PH_FIRST) begin
          hold  <= data_in;
          phase <= PH_SECOND;
          if (start_in) pair_cnt <= '0;
        end else begin
          data_out <= {hold, data_in};
          pair_cnt <= pair_cnt + CNT_W'(1);
          phase    <= PH_FIRST;
        end
      end
    end
  end
endmodule

// File: tb/tb_wifi_rx_stop_convolution_half.sv
// tb_wifi_rx_stop_convolution_half: three parameterisations driven by one stream, checked against a frame-level model
module tb_wifi_rx_stop_convolution_half;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       v = 1'b0;
  logic       s = 1'b0;
  logic [3:0] d = 4'd0;
  logic       run = 1'b0;
  int checks = 0;
  int errors = 0;
  logic        vo0, vo1, vo2, er0, er1, er2;
  logic [1:0]  do0, do2;
  logic [7:0]  do1;
  logic [11:0] cnt0, cnt1;
  logic [1:0]  cnt2;
  always #5 clk = ~clk;
  wifi_rx_stop_convolution_half #(.SOFT_W(1), .CNT_W(12)) dut0 (
    .clk(clk), .reset(reset), .valid_in(v), .start_in(s), .data_in(d[0]),
    .valid_out(vo0), .data_out(do0), .pair_cnt(cnt0), .odd_err(er0));
  wifi_rx_stop_convolution_half #(.SOFT_W(4), .CNT_W(12)) dut1 (
    .clk(clk), .reset(reset), .valid_in(v), .start_in(s), .data_in(d),
    .valid_out(vo1), .data_out(do1), .pair_cnt(cnt1), .odd_err(er1));
  wifi_rx_stop_convolution_half #(.SOFT_W(1), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .valid_in(v), .start_in(s), .data_in(d[0]),
    .valid_out(vo2), .data_out(do2), .pair_cnt(cnt2), .odd_err(er2));
  // model: a frame is a count of valid bits since the last start; every even count completes a pair
  int         nbits = 0;
  logic [3:0] first = 4'd0;
  logic       e_vo = 1'b0;
  logic       e_err = 1'b0;
  logic [7:0] e_pair = 8'd0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      nbits = 0; first = 4'd0; e_vo = 1'b0; e_err = 1'b0; e_pair = 8'd0;
    end else begin
      e_vo = 1'b0;
      e_err = 1'b0;
      if (v) begin
        if (s) begin
          e_err = (nbits % 2) == 1;
          nbits = 0;
        end
        nbits = nbits + 1;
        if (nbits % 2 == 1) first = d;
        else begin
          e_vo = 1'b1;
          e_pair = {first, d};
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  int pairs;
  logic [13:0] log0[$];
  logic [7:0]  log1[$];
  logic [1:0]  log2[$];
  int err_seen = 0;
  // compare every DUT output against the model on each falling edge
  always @(negedge clk) begin
    if (run) begin
      pairs = nbits / 2;
      chk("vo0", 32'(vo0), 32'(e_vo));
      chk("vo1", 32'(vo1), 32'(e_vo));
      chk("vo2", 32'(vo2), 32'(e_vo));
      chk("err0", 32'(er0), 32'(e_err));
      chk("err1", 32'(er1), 32'(e_err));
      chk("err2", 32'(er2), 32'(e_err));
      chk("do0", 32'(do0), 32'({e_pair[4], e_pair[0]}));
      chk("do1", 32'(do1), 32'(e_pair));
      chk("do2", 32'(do2), 32'({e_pair[4], e_pair[0]}));
      chk("cnt0", 32'(cnt0), 32'(pairs % 4096));
      chk("cnt1", 32'(cnt1), 32'(pairs % 4096));
      chk("cnt2", 32'(cnt2), 32'(pairs % 4));
      if (vo0) log0.push_back({do0, cnt0});
      if (vo1) log1.push_back(do1);
      if (vo2) log2.push_back(cnt2);
      if (er0) err_seen++;
    end
  end
  task automatic bit_in(input logic [3:0] val, input logic st, input int gap);
    v = 1'b1; s = st; d = val;
    @(posedge clk); #1;
    v = 1'b0; s = 1'b1; d = 4'($urandom_range(0, 15));
    repeat (gap) begin
      @(posedge clk); #1;
    end
    s = 1'b0;
  endtask
  int ed[15] = '{2, 3, 1, 2, 3, 1, 3, 1, 3, 1, 2, 0, 3, 1, 1};
  int ec[15] = '{1, 2, 3, 1, 2, 3, 1, 1, 1, 1, 2, 3, 4, 5, 1};
  int e2[5]  = '{1, 2, 3, 0, 1};
  int t1[6]  = '{1, 0, 1, 1, 0, 1};
  int t5[10] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 1};
  initial begin
    #2 reset = 1'b0;
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) bit_in(4'(t1[i]), i == 0, 0);
    for (int i = 0; i < 6; i++) bit_in(4'(t1[i]), i == 0, 2);
    bit_in(4'd1, 1'b1, 0);
    bit_in(4'd1, 1'b0, 1);
    bit_in(4'd0, 1'b0, 0);
    bit_in(4'd0, 1'b1, 0);
    bit_in(4'd1, 1'b0, 2);
    bit_in(4'h9, 1'b1, 0);
    bit_in(4'h3, 1'b0, 1);
    for (int i = 0; i < 10; i++) bit_in(4'(t5[i]), i == 0, 0);
    bit_in(4'd1, 1'b0, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    bit_in(4'd0, 1'b0, 0);
    bit_in(4'd1, 1'b0, 3);
    run = 1'b0;
    chk("pairs0", 32'(log0.size()), 32'd15);
    chk("pairs1", 32'(log1.size()), 32'd15);
    chk("pairs2", 32'(log2.size()), 32'd15);
    chk("odd_err_pulses", 32'(err_seen), 32'd1);
    if (log0.size() == 15 && log1.size() == 15 && log2.size() == 15) begin
      for (int i = 0; i < 15; i++) begin
        chk("lit_data0", 32'(log0[i][13:12]), 32'(ed[i]));
        chk("lit_cnt0", 32'(log0[i][11:0]), 32'(ec[i]));
      end
      chk("lit_data1", 32'(log1[8]), 32'h93);
      for (int i = 0; i < 5; i++) chk("lit_cnt2", 32'(log2[9 + i]), 32'(e2[i]));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
